// File: rtl/dl_pkg.sv
// Shared definitions for the cross-clock sample delay line (writer and reader sides).
package dl_pkg;
  localparam int DL_DW = 16;
  localparam int DL_AW = 17;

  typedef enum logic [1:0] {PRIME, RUN, DRAIN} state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/dl_sync2.sv
// Two-flop synchroniser for a Gray-coded bus crossing into the local clock.
module dl_sync2 #(
  parameter int W = 18
) (
  input  logic         clk_a,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk_a) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/delay_line_writer.sv
// clk_a-side producer of the sample delay line: RAM port-A writes, Gray write pointer, rd_enable.
// Optional DLW_DROP_EN: never backpressure; discard samples when full/draining and count them.
module delay_line_writer
  import dl_pkg::*;
#(
  parameter int DW    = DL_DW,
  parameter int AW    = DL_AW,
  parameter int DELAY = 1000
) (
  input  logic          clk_a,
  input  logic          reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          flush,
  input  logic [AW:0]   rd_ptr_gray_b,
  output logic [AW:0]   wr_ptr_gray,
  output logic          rd_enable,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW:0]   fill
`ifdef DLW_DROP_EN
  , output logic [31:0] drop_cnt
`endif
);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] DELAY_P = PW'(DELAY);
  localparam logic [PW-1:0] ONE     = PW'(1);

  logic [PW-1:0] wr_ptr, wr_ptr_inc, prime_cnt, prime_cnt_nxt;
  logic [PW-1:0] rd_gray_s, rd_ptr_sync;
  state_t        state, state_nxt;
  logic          full, wr;

  dl_sync2 #(.W(PW)) u_rd_sync (
    .clk_a   (clk_a),
    .reset_n (reset_n),
    .d       (rd_ptr_gray_b),
    .q       (rd_gray_s)
  );

  assign rd_ptr_sync = PW'(gray2bin(32'(rd_gray_s)));
  assign fill        = wr_ptr - rd_ptr_sync;
  assign full        = (fill == DEPTH_P);
  assign wr_ptr_inc  = wr_ptr + ONE;

`ifdef DLW_DROP_EN
  assign s_ready = 1'b1;
  assign wr      = s_valid && !full && (state != DRAIN);
`else
  assign s_ready = !full && (state != DRAIN);
  assign wr      = s_valid && s_ready;
`endif

  // A write coinciding with flush still lands; flush only affects the FSM.
  always_comb begin
    state_nxt     = state;
    prime_cnt_nxt = prime_cnt;
    unique case (state)
      PRIME: begin
        if (flush) prime_cnt_nxt = '0;
        else if (wr) begin
          prime_cnt_nxt = prime_cnt + ONE;
          if (prime_cnt + ONE == DELAY_P) state_nxt = RUN;
        end
      end
      RUN:   if (flush) state_nxt = DRAIN;
      DRAIN: begin
        if (fill == '0) begin
          state_nxt     = PRIME;
          prime_cnt_nxt = '0;
        end
      end
      default: state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (!reset_n) begin
      state       <= PRIME;
      prime_cnt   <= '0;
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
      rd_enable   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state     <= state_nxt;
      prime_cnt <= prime_cnt_nxt;
      rd_enable <= (state_nxt != PRIME);
      mem_we    <= wr;
      if (wr) begin
        mem_addr    <= wr_ptr[AW-1:0];
        mem_wdata   <= s_data;
        wr_ptr      <= wr_ptr_inc;
        wr_ptr_gray <= PW'(bin2gray(32'(wr_ptr_inc)));
      end
    end
  end

`ifdef DLW_DROP_EN
  always_ff @(posedge clk_a) begin
    if (!reset_n) drop_cnt <= '0;
    else if (s_valid && !wr && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_delay_line_writer.sv
// Directed + randomized bench for delay_line_writer (AW=4, DELAY=5) against a pointer-arithmetic model.
module tb_delay_line_writer;
  localparam int DW = 16, AW = 4, DELAY = 5, DEPTH = 16, PMOD = 32;

  logic          clk_a = 1'b0;
  logic          reset_n, s_valid, s_ready, flush, rd_enable, mem_we;
  logic [DW-1:0] s_data, mem_wdata;
  logic [AW:0]   rd_ptr_gray_b, wr_ptr_gray, fill;
  logic [AW-1:0] mem_addr;
`ifdef DLW_DROP_EN
  logic [31:0]   drop_cnt;
`endif

  int errors = 0, checks = 0;
  // model: free pointers mod 32, reader pointer as seen two edges later, priming count, mode bits
  int m_wr, m_rd, s1, s2, m_prime, m_drop, exp_addr, exp_data;
  bit m_run, m_drain, exp_we;

  delay_line_writer #(.DW(DW), .AW(AW), .DELAY(DELAY)) dut (
    .clk_a(clk_a), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .flush(flush), .rd_ptr_gray_b(rd_ptr_gray_b), .wr_ptr_gray(wr_ptr_gray), .rd_enable(rd_enable),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fill(fill)
`ifdef DLW_DROP_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk_a = ~clk_a;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_rd(input int v);
    m_rd = v % PMOD;
    rd_ptr_gray_b = 5'(gray(m_rd));
  endtask

  task automatic tick();
    int  fill_pre;
    bit  acc;
    fill_pre = (m_wr - s2) & (PMOD - 1);
    acc = s_valid && (fill_pre != DEPTH) && !m_drain;
    if (!reset_n) begin
      m_wr = 0; s1 = 0; s2 = 0; m_prime = 0; m_run = 0; m_drain = 0; m_drop = 0;
      exp_we = 0; exp_addr = 0; exp_data = 0;
    end else begin
      if (s_valid && !acc) m_drop++;
      exp_we = acc;
      if (acc) begin
        exp_addr = m_wr % DEPTH;
        exp_data = int'(s_data);
        m_wr = (m_wr + 1) % PMOD;
      end
      if (m_run) begin
        if (flush) begin m_run = 0; m_drain = 1; end
      end else if (m_drain) begin
        if (fill_pre == 0) begin m_drain = 0; m_prime = 0; end
      end else if (flush) m_prime = 0;
      else if (acc) begin
        m_prime++;
        if (m_prime == DELAY) m_run = 1;
      end
      s2 = s1; s1 = m_rd;
    end
    @(posedge clk_a); #1;
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(exp_data));
    end
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray(m_wr)));
    chk("rd_enable", 32'(rd_enable), 32'(m_run || m_drain));
    chk("fill", 32'(fill), 32'((m_wr - s2) & (PMOD - 1)));
`ifdef DLW_DROP_EN
    chk("s_ready", 32'(s_ready), 32'd1);
    chk("drop_cnt", drop_cnt, 32'(m_drop));
`else
    chk("s_ready", 32'(s_ready), 32'(!(((m_wr - s2) & (PMOD - 1)) == DEPTH) && !m_drain));
`endif
  endtask

  initial begin
    reset_n = 0; s_valid = 0; s_data = '0; flush = 0; set_rd(0);
    tick(); tick();
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    reset_n = 1;

    // 1: five back-to-back writes prime the line
    for (int i = 1; i <= 5; i++) begin s_valid = 1; s_data = 16'(i); tick(); end
    chk("t1_rden", 32'(rd_enable), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd4);

    // 2: reader parked at 0 until full, then released
    for (int i = 0; i < 14; i++) begin s_data = 16'($urandom); tick(); end
    chk("t2_fill", 32'(fill), 32'd16);
    chk("t2_ready", 32'(s_ready), 32'd0);
    s_valid = 0; set_rd(3);
    for (int i = 0; i < 3; i++) tick();
    chk("t2_ready_back", 32'(s_ready), 32'd1);

    // 3: random traffic with a tracking reader, pointers wrap
    for (int i = 0; i < 90; i++) begin
      s_valid = ($urandom % 4) != 0;
      s_data  = 16'($urandom);
      if ($urandom % 2 == 1) set_rd(m_rd + int'($urandom_range(0, (m_wr - m_rd) & (PMOD - 1))));
      tick();
    end

    // 4: flush in RUN with six samples outstanding
    s_valid = 0; set_rd(m_wr);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 6; i++) begin s_valid = 1; s_data = 16'($urandom); tick(); end
    s_valid = 0; tick(); tick();
    chk("t4_fill", 32'(fill), 32'd6);
    flush = 1; tick(); flush = 0;
    s_valid = 1; tick(); tick();
    chk("t4_ready", 32'(s_ready), `ifdef DLW_DROP_EN 32'd1 `else 32'd0 `endif);
    chk("t4_rden", 32'(rd_enable), 32'd1);
    s_valid = 0; set_rd(m_wr);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_prime", 32'(rd_enable), 32'd0);
    for (int i = 0; i < 5; i++) begin s_valid = 1; s_data = 16'($urandom); tick(); end
    chk("t4_rearm", 32'(rd_enable), 32'd1);

    // 5: reset pulse inside a write burst
    for (int i = 0; i < 3; i++) begin s_data = 16'($urandom); tick(); end
    reset_n = 0; set_rd(0); tick();
    chk("t5_we", 32'(mem_we), 32'd0);
    chk("t5_gray", 32'(wr_ptr_gray), 32'd0);
    chk("t5_rden", 32'(rd_enable), 32'd0);
    reset_n = 1; s_data = 16'h00aa; tick();
    chk("t5_addr0", 32'(mem_addr), 32'd0);
    chk("t5_data", 32'(mem_wdata), 32'h00aa);

`ifdef DLW_DROP_EN
    // 6: fill up, then offer three more samples that must be discarded
    for (int i = 0; i < 15; i++) begin s_data = 16'($urandom); tick(); end
    for (int i = 0; i < 3; i++) begin s_data = 16'($urandom); tick(); end
    chk("t6_we", 32'(mem_we), 32'd0);
    chk("t6_drop", drop_cnt, 32'd3);
    chk("t6_ready", 32'(s_ready), 32'd1);
`endif
    s_valid = 0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
